wvb_readout_arbiter: RTL and testbench
======================================

Name: wvb_readout_arbiter

Overview:
Round-robin readout scheduler shared by P_N_CHAN waveform buffers (one per ADC channel). It picks a channel with a pending header and pops its header. It then sequences that channel's wvb_rdreq / wvb_rddone / hdr_rdreq handshake and serialises the samples onto one tagged output stream feeding the downstream readout FIFO. It sits between the per-channel waveform buffers and the readout/packetiser logic.

Parameters:
P_N_CHAN, 24, number of waveform buffers served
P_CHAN_WIDTH, 5, width of channel index (>= clog2(P_N_CHAN))
P_DATA_WIDTH, 22, waveform word width
P_HDR_WIDTH, 80, header word width
P_ADR_WIDTH, 12, waveform buffer address width
P_START_LSB, 12, LSB of start_addr field in header
P_STOP_LSB, 0, LSB of stop_addr field in header
P_RD_LATENCY, 2, cycles from wvb_rdreq to valid wvb_data at input

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
arb_en  in  1  enable arbitration of new events
hdr_empty  in  P_N_CHAN  per-channel header FIFO empty (FWFT: hdr_data valid when low)
hdr_data  in  P_N_CHAN*P_HDR_WIDTH  per-channel header, channel i at [i*W +: W]
wvb_data  in  P_N_CHAN*P_DATA_WIDTH  per-channel waveform data, same packing
hdr_rdreq  out  P_N_CHAN  one-hot header pop
wvb_rdreq  out  P_N_CHAN  one-hot waveform read request
wvb_rddone  out  P_N_CHAN  one-hot end-of-event pulse
out_afull  in  1  downstream FIFO almost full (>= P_RD_LATENCY+1 words slack)
dout  out  P_DATA_WIDTH  waveform sample
dout_valid  out  1  dout qualifier
dout_sop  out  1  first sample of event
dout_eop  out  1  last sample of event
dout_chan  out  P_CHAN_WIDTH  source channel of current word
dout_hdr  out  P_HDR_WIDTH  latched header, stable from sop through eop
busy  out  1  event in progress (any state but IDLE)

Behaviour:
- Reset: state IDLE; all outputs 0; rr pointer = P_N_CHAN-1 (so channel 0 wins first); valid pipeline cleared.
- IDLE: if arb_en and any !hdr_empty -> ARB.
- ARB (1 cycle): grant = first non-empty channel searching from rr+1 upward with wrap; latch grant, hdr_data[grant]; rr <= grant; compute len = ((stop-start) mod 2^P_ADR_WIDTH)+1, width P_ADR_WIDTH+1 (range 1..4096) -> DATA. If all empty (arb_en dropped race), -> IDLE.
- DATA: each cycle with !out_afull assert wvb_rdreq[grant], cnt++. First request tagged sop, request with cnt==len-1 tagged eop -> DONE after it. out_afull high: no request, hold.
- DONE (1 cycle): pulse wvb_rddone[grant] and hdr_rdreq[grant] together -> DRAIN.
- DRAIN: wait P_RD_LATENCY cycles so the last word leaves the pipeline; then IDLE (or ARB directly if arb_en and a header is pending).
- Output pipeline: rdreq/sop/eop delayed exactly P_RD_LATENCY cycles -> dout_valid/sop/eop. dout = wvb_data[grant] muxed by latched grant. Grant is held until DRAIN completes.
- dout_hdr/dout_chan are updated in ARB and held until the next ARB.
- arb_en deassert mid-event: the current event completes; no new grant.
- len==1: sop and eop on the same word.
- Reset mid-event: immediate return to IDLE. No rddone/hdr_rdreq is issued; in-flight valids are dropped. The buffers' own reset is simultaneous.
- At most one bit set in any rdreq/rddone vector in any cycle.

Optional Feature:
WVB_ARB_STATS_EN: adds outputs evt_cnt (32) and word_cnt (32), free-running wrap counters.
- evt_cnt increments on each DONE; word_cnt increments on each dout_valid; both cleared by rst.
- Without the macro the ports and counters are absent.

Decomposition:
- Shared package wvb_pkg: header field LSB constants, P_ADR_WIDTH, a function computing event length with wrap, and state encoding localparams (IDLE, ARB, DATA, DONE, DRAIN).
- One sub-module, rr_arbiter: combinational round-robin grant from request vector and pointer, parameterised by P_N_CHAN.

Test Plan:
- Ch3 header start=0x010 stop=0x013, others empty -> 4 dout_valid words from ch3, sop on first, eop on fourth, dout_chan=3; one rddone[3] and hdr_rdreq[3] pulse.
- Ch0 and ch5 both pending, 2 words each -> order ch0 then ch5; then ch0 reloaded with ch5 also pending -> ch5 served next only if rr=0, ch0 otherwise.
- start=0xFFE stop=0x001 -> len=4, 4 rdreqs, eop on fourth word.
- out_afull held high 5 cycles mid-event, len=8 -> rdreqs pause, no lost or duplicated words, 8 words total.
- start==stop -> single word with sop and eop both high.
- rst asserted mid-DATA -> next cycle all outputs 0, busy=0; arb_en=0 mid-event -> event finishes, then IDLE while headers are still pending.

Source files
------------

// File: rtl/wvb_pkg.sv
// Shared types and helpers for the waveform-buffer readout arbiter.
// Header field positions, state encoding and event length with address wrap.
package wvb_pkg;

    localparam int WVB_ADR_WIDTH = 12;
    localparam int WVB_START_LSB = 12;
    localparam int WVB_STOP_LSB  = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_DATA,
        S_DONE,
        S_DRAIN
    } state_t;

    // stop may sit below start when the ring buffer wrapped; range 1..2^W
    function automatic logic [WVB_ADR_WIDTH:0] wvb_len(
        input logic [WVB_ADR_WIDTH-1:0] start,
        input logic [WVB_ADR_WIDTH-1:0] stop
    );
        logic [WVB_ADR_WIDTH-1:0] diff;
        diff = stop - start;
        return {1'b0, diff} + 1'b1;
    endfunction

endpackage

// File: rtl/wvb_readout_arbiter_rr.sv
// Combinational round-robin pick: first requester after ptr, wrapping.
// ptr holds the last winner, so the search starts at ptr+1.
module rr_arbiter #(
    parameter int P_N_CHAN     = 24,
    parameter int P_CHAN_WIDTH = 5
) (
    input  logic [P_N_CHAN-1:0]     req,
    input  logic [P_CHAN_WIDTH-1:0] ptr,
    output logic [P_CHAN_WIDTH-1:0] gnt,
    output logic                    gnt_valid
);

    localparam int SW = P_CHAN_WIDTH + 1;

    always_comb begin
        logic [SW-1:0] sum;
        logic [SW-1:0] idx;
        gnt       = '0;
        gnt_valid = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 1; k <= P_N_CHAN; k++) begin
            sum = {1'b0, ptr} + SW'(k);
            idx = (sum >= SW'(P_N_CHAN)) ? sum - SW'(P_N_CHAN) : sum;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt       = idx[P_CHAN_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/wvb_readout_arbiter.sv
// Round-robin readout of per-channel waveform buffers onto one tagged stream.
// Optional: define WVB_ARB_STATS_EN for evt_cnt / word_cnt counters.
module wvb_readout_arbiter
    import wvb_pkg::*;
#(
    parameter int P_N_CHAN     = 24,
    parameter int P_CHAN_WIDTH = 5,
    parameter int P_DATA_WIDTH = 22,
    parameter int P_HDR_WIDTH  = 80,
    parameter int P_ADR_WIDTH  = WVB_ADR_WIDTH,
    parameter int P_START_LSB  = WVB_START_LSB,
    parameter int P_STOP_LSB   = WVB_STOP_LSB,
    parameter int P_RD_LATENCY = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             arb_en,
    input  logic [P_N_CHAN-1:0]              hdr_empty,
    input  logic [P_N_CHAN*P_HDR_WIDTH-1:0]  hdr_data,
    input  logic [P_N_CHAN*P_DATA_WIDTH-1:0] wvb_data,
    output logic [P_N_CHAN-1:0]              hdr_rdreq,
    output logic [P_N_CHAN-1:0]              wvb_rdreq,
    output logic [P_N_CHAN-1:0]              wvb_rddone,
    input  logic                             out_afull,
    output logic [P_DATA_WIDTH-1:0]          dout,
    output logic                             dout_valid,
    output logic                             dout_sop,
    output logic                             dout_eop,
    output logic [P_CHAN_WIDTH-1:0]          dout_chan,
    output logic [P_HDR_WIDTH-1:0]           dout_hdr,
    output logic                             busy
`ifdef WVB_ARB_STATS_EN
    ,
    output logic [31:0]                      evt_cnt,
    output logic [31:0]                      word_cnt
`endif
);

    localparam int DRW = $clog2(P_RD_LATENCY) + 1;

    state_t state, state_d;

    logic [P_CHAN_WIDTH-1:0] grant, rr, gnt_idx;
    logic                    gnt_valid;
    logic [P_ADR_WIDTH:0]    len, cnt;
    logic [DRW-1:0]          drain_cnt;
    logic [P_HDR_WIDTH-1:0]  sel_hdr;
    logic [P_DATA_WIDTH-1:0] sel_data;
    logic                    pending, rd, rd_sop, rd_eop, fin;

    logic [P_RD_LATENCY-1:0] vld_p, sop_p, eop_p;

    assign pending = |(~hdr_empty);

    rr_arbiter #(
        .P_N_CHAN     (P_N_CHAN),
        .P_CHAN_WIDTH (P_CHAN_WIDTH)
    ) u_rr (
        .req       (~hdr_empty),
        .ptr       (rr),
        .gnt       (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        state_d = state;
        rd      = 1'b0;
        rd_sop  = 1'b0;
        rd_eop  = 1'b0;
        fin     = 1'b0;
        unique case (state)
            S_IDLE: if (arb_en && pending) state_d = S_ARB;
            S_ARB:  state_d = gnt_valid ? S_DATA : S_IDLE;
            S_DATA: begin
                if (!out_afull) begin
                    rd     = 1'b1;
                    rd_sop = (cnt == '0);
                    rd_eop = (cnt == len - 1'b1);
                    if (rd_eop) state_d = S_DONE;
                end
            end
            S_DONE: begin
                fin     = 1'b1;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt == DRW'(P_RD_LATENCY - 1))
                    state_d = (arb_en && pending) ? S_ARB : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // gnt_idx picks the header at ARB; grant picks the data lane afterwards
    always_comb begin
        sel_hdr    = '0;
        sel_data   = '0;
        wvb_rdreq  = '0;
        wvb_rddone = '0;
        hdr_rdreq  = '0;
        for (int i = 0; i < P_N_CHAN; i++) begin
            if (gnt_idx == P_CHAN_WIDTH'(i))
                sel_hdr = hdr_data[i*P_HDR_WIDTH +: P_HDR_WIDTH];
            if (grant == P_CHAN_WIDTH'(i)) begin
                sel_data      = wvb_data[i*P_DATA_WIDTH +: P_DATA_WIDTH];
                wvb_rdreq[i]  = rd;
                wvb_rddone[i] = fin;
                hdr_rdreq[i]  = fin;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            grant     <= '0;
            rr        <= P_CHAN_WIDTH'(P_N_CHAN - 1);
            dout_hdr  <= '0;
            len       <= '0;
            cnt       <= '0;
            drain_cnt <= '0;
            vld_p     <= '0;
            sop_p     <= '0;
            eop_p     <= '0;
        end else begin
            state    <= state_d;
            vld_p[0] <= rd;
            sop_p[0] <= rd_sop;
            eop_p[0] <= rd_eop;
            for (int i = 1; i < P_RD_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                sop_p[i] <= sop_p[i-1];
                eop_p[i] <= eop_p[i-1];
            end
            if (state == S_ARB && gnt_valid) begin
                grant    <= gnt_idx;
                rr       <= gnt_idx;
                dout_hdr <= sel_hdr;
                len      <= wvb_len(sel_hdr[P_START_LSB +: P_ADR_WIDTH],
                                    sel_hdr[P_STOP_LSB +: P_ADR_WIDTH]);
                cnt      <= '0;
            end
            if (rd) cnt <= cnt + 1'b1;
            if (state == S_DONE) drain_cnt <= '0;
            else if (state == S_DRAIN) drain_cnt <= drain_cnt + 1'b1;
        end
    end

    assign dout_valid = vld_p[P_RD_LATENCY-1];
    assign dout_sop   = sop_p[P_RD_LATENCY-1];
    assign dout_eop   = eop_p[P_RD_LATENCY-1];
    assign dout       = dout_valid ? sel_data : '0;
    assign dout_chan  = grant;
    assign busy       = (state != S_IDLE);

`ifdef WVB_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            if (fin) evt_cnt <= evt_cnt + 1'b1;
            if (dout_valid) word_cnt <= word_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_wvb_readout_arbiter.sv
// Directed bench for wvb_readout_arbiter with a small header-FIFO and
// buffer model (2-cycle read latency) driving the per-channel inputs.
module tb_wvb_readout_arbiter;

    localparam int N  = 24;
    localparam int CW = 5;
    localparam int DW = 22;
    localparam int HW = 80;

    logic            clk, rst, arb_en, out_afull;
    logic [N-1:0]    hdr_empty, hdr_rdreq, wvb_rdreq, wvb_rddone;
    logic [N*HW-1:0] hdr_data;
    logic [N*DW-1:0] wvb_data;
    logic [DW-1:0]   dout;
    logic            dout_valid, dout_sop, dout_eop, busy;
    logic [CW-1:0]   dout_chan;
    logic [HW-1:0]   dout_hdr;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [4:0]  chan;
        logic [21:0] data;
    } word_t;

    word_t       wq[$];
    logic [79:0] hq[N][$];
    logic [11:0] rcnt[N];
    logic [11:0] a_d1, a_d2;
    logic [N-1:0] seen_rd, seen_pop;
    int n_rd, n_multi, n_afull_rd;
    int n_done[N], n_pop[N];
    int n_cmp, n_bad;

    wvb_readout_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .arb_en     (arb_en),
        .hdr_empty  (hdr_empty),
        .hdr_data   (hdr_data),
        .wvb_data   (wvb_data),
        .hdr_rdreq  (hdr_rdreq),
        .wvb_rdreq  (wvb_rdreq),
        .wvb_rddone (wvb_rddone),
        .out_afull  (out_afull),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_sop   (dout_sop),
        .dout_eop   (dout_eop),
        .dout_chan  (dout_chan),
        .dout_hdr   (dout_hdr),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] mk_hdr(input logic [11:0] s,
                                           input logic [11:0] e);
        return {8'hA5, 48'h0, s, e};
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            hdr_empty[i] = (hq[i].size() == 0);
            hdr_data[i*HW +: HW] = hdr_empty[i] ? 80'h0 : hq[i][0];
            wvb_data[i*DW +: DW] = {5'(i), 5'b0, a_d2};
        end
    endtask

    task automatic load(input int c, input logic [11:0] s,
                        input logic [11:0] e);
        hq[c].push_back(mk_hdr(s, e));
        drive_inputs();
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // monitor: sample everything mid-cycle
    always @(negedge clk) begin
        seen_rd  = wvb_rdreq;
        seen_pop = hdr_rdreq;
        if ($countones(wvb_rdreq) > 1 || $countones(wvb_rddone) > 1 ||
            $countones(hdr_rdreq) > 1 || wvb_rddone != hdr_rdreq)
            n_multi++;
        if (|wvb_rdreq && out_afull) n_afull_rd++;
        n_rd += $countones(wvb_rdreq);
        for (int c = 0; c < N; c++) begin
            if (wvb_rddone[c]) n_done[c]++;
            if (hdr_rdreq[c]) n_pop[c]++;
        end
        if (dout_valid)
            wq.push_back({dout_sop, dout_eop, dout_chan, dout});
    end

    // buffer model: address of each request appears 2 cycles later
    always @(posedge clk) begin
        #1;
        a_d2 = a_d1;
        a_d1 = 12'h0;
        for (int c = 0; c < N; c++) begin
            if (seen_rd[c]) begin
                if (hq[c].size() > 0) a_d1 = hq[c][0][23:12] + rcnt[c];
                rcnt[c] = rcnt[c] + 12'h1;
            end
        end
        for (int c = 0; c < N; c++) begin
            if (seen_pop[c]) begin
                if (hq[c].size() > 0) void'(hq[c].pop_front());
                rcnt[c] = 12'h0;
            end
        end
        drive_inputs();
    end

    task automatic expect_event(input int c, input logic [11:0] s,
                                input int n);
        word_t w, x;
        if (wq.size() < n) begin
            check($sformatf("words_ch%0d", c), 32'(wq.size()), 32'(n));
            wq.delete();
            return;
        end
        for (int k = 0; k < n; k++) begin
            w      = wq.pop_front();
            x.sop  = (k == 0);
            x.eop  = (k == n - 1);
            x.chan = 5'(c);
            x.data = {5'(c), 5'b0, s + 12'(k)};
            check($sformatf("ev_ch%0d_w%0d", c, k), 32'(w), 32'(x));
        end
    endtask

    task automatic run_idle(input string tag);
        int k;
        k = 0;
        repeat (3) @(negedge clk);
        while (busy && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_rd(input int n0, input int n);
        int k;
        k = 0;
        while (n_rd - n0 < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("wait_rd", 32'(n_rd - n0 >= n), 32'd1);
    endtask

    initial begin
        int n0, n1;
        rst = 1'b1;
        arb_en = 1'b0;
        out_afull = 1'b0;
        a_d1 = '0;
        a_d2 = '0;
        seen_rd = '0;
        seen_pop = '0;
        n_rd = 0; n_multi = 0; n_afull_rd = 0; n_cmp = 0; n_bad = 0;
        for (int c = 0; c < N; c++) begin
            rcnt[c] = '0;
            n_done[c] = 0;
            n_pop[c] = 0;
        end
        drive_inputs();
        repeat (2) step();
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_rdreq", 32'(wvb_rdreq), 32'd0);
        check("rst_hdr_rdreq", 32'(hdr_rdreq), 32'd0);
        check("rst_chan", 32'(dout_chan), 32'd0);
        step();
        rst = 1'b0;

        // single 4-word event on ch3
        n0 = n_rd;
        load(3, 12'h010, 12'h013);
        arb_en = 1'b1;
        run_idle("t1");
        expect_event(3, 12'h010, 4);
        check("t1_done", 32'(n_done[3]), 32'd1);
        check("t1_pop", 32'(n_pop[3]), 32'd1);
        check("t1_chan", 32'(dout_chan), 32'd3);
        check("t1_hdr_lo", dout_hdr[31:0], 32'h0001_0013);
        check("t1_hdr_hi", dout_hdr[79:48], 32'hA500_0000);
        check("t1_rd", 32'(n_rd - n0), 32'd4);

        // round-robin order from a fresh pointer
        step();
        rst = 1'b1;
        arb_en = 1'b0;
        step();
        rst = 1'b0;
        load(0, 12'h100, 12'h101);
        load(5, 12'h200, 12'h201);
        arb_en = 1'b1;
        run_idle("t2a");
        expect_event(0, 12'h100, 2);
        expect_event(5, 12'h200, 2);
        arb_en = 1'b0;
        step();
        load(0, 12'h400, 12'h401);
        load(0, 12'h500, 12'h501);
        load(5, 12'h600, 12'h601);
        arb_en = 1'b1;
        run_idle("t2b");
        expect_event(0, 12'h400, 2);
        expect_event(5, 12'h600, 2);
        expect_event(0, 12'h500, 2);
        check("t2_extra", 32'(wq.size()), 32'd0);

        // address wrap
        n0 = n_rd;
        load(7, 12'hFFE, 12'h001);
        run_idle("t3");
        expect_event(7, 12'hFFE, 4);
        check("t3_rd", 32'(n_rd - n0), 32'd4);

        // back-pressure mid-event
        n0 = n_rd;
        load(2, 12'h020, 12'h027);
        wait_rd(n0, 3);
        step();
        out_afull = 1'b1;
        n1 = n_rd;
        repeat (5) step();
        check("t4_pause", 32'(n_rd - n1), 32'd0);
        out_afull = 1'b0;
        run_idle("t4");
        expect_event(2, 12'h020, 8);
        check("t4_rd", 32'(n_rd - n0), 32'd8);
        check("t4_afull_rd", 32'(n_afull_rd), 32'd0);

        // single-word event
        load(9, 12'h055, 12'h055);
        run_idle("t5");
        expect_event(9, 12'h055, 1);

        // reset in the middle of DATA
        n0 = n_rd;
        load(4, 12'h300, 12'h30F);
        wait_rd(n0, 3);
        step();
        rst = 1'b1;
        hq[4].delete();
        rcnt[4] = '0;
        drive_inputs();
        @(posedge clk);
        @(negedge clk);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_valid", 32'({dout_valid, dout_sop, dout_eop}), 32'd0);
        check("t6_rdreq", 32'(wvb_rdreq | wvb_rddone | hdr_rdreq), 32'd0);
        check("t6_dout", 32'(dout), 32'd0);
        check("t6_chan", 32'(dout_chan), 32'd0);
        check("t6_done", 32'(n_done[4] + n_pop[4]), 32'd0);
        step();
        rst = 1'b0;
        wq.delete();

        // arb_en dropped mid-event
        n0 = n_rd;
        load(6, 12'h700, 12'h703);
        load(8, 12'h800, 12'h801);
        wait_rd(n0, 1);
        arb_en = 1'b0;
        run_idle("t7");
        expect_event(6, 12'h700, 4);
        check("t7_pending", 32'(hdr_empty[8]), 32'd0);
        check("t7_pop8", 32'(n_pop[8]), 32'd0);
        repeat (5) @(negedge clk);
        check("t7_stay_idle", 32'(busy), 32'd0);
        step();
        arb_en = 1'b1;
        run_idle("t7b");
        expect_event(8, 12'h800, 2);
        check("end_extra", 32'(wq.size()), 32'd0);
        check("onehot", 32'(n_multi), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
